// File: rtl/sipo_ctrl_pkg.sv
// Shared state encoding for the SIPO frame controller and its bench monitors.
package sipo_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } sipo_state_e;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift path for one serial word, MSB first, with synchronous clear and shift enable.
module sipo_shift_core #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  Clk_In,
   input  logic                  Reset_N_In,
   input  logic                  Clear_In,
   input  logic                  Shift_En_In,
   input  logic                  Data_In,
   output logic [DATA_WIDTH-1:0] Word_Out
);

   // Only W-1 bits are stored; the final bit completes the word combinationally.
   logic [DATA_WIDTH-2:0] pending_q, pending_d;

   assign Word_Out = {pending_q, Data_In};

   always_comb begin
      pending_d = Clear_In ? '0 : pending_q;
      if (Shift_En_In) begin
         pending_d = Clear_In ? (DATA_WIDTH-1)'(Data_In) : Word_Out[DATA_WIDTH-2:0];
      end
   end

   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: rtl/sipo_frame_controller.sv
// Frames a serial bitstream into words and hands them to a consumer over valid/ready,
// holding one word and flagging overrun when a completed word cannot be stored.
module sipo_frame_controller
   import sipo_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter bit          CONTINUOUS = 1'b0,
   localparam int unsigned COUNT_W   = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  Clk_In,
   input  logic                  Reset_N_In,
   input  logic                  Enable_In,
   input  logic                  Frame_Start_In,
   input  logic                  Serial_Valid_In,
   input  logic                  Serial_Data_In,
   input  logic                  Word_Ready_In,
   input  logic                  Clear_Overrun_In,
   output logic [DATA_WIDTH-1:0] Word_Data_Out,
   output logic                  Word_Valid_Out,
   output logic                  Busy_Out,
   output logic [COUNT_W-1:0]    Bit_Count_Out,
   output logic                  Overrun_Out
);

   localparam logic [COUNT_W-1:0] LAST_BIT = COUNT_W'(DATA_WIDTH - 1);

   sipo_state_e           state_q, state_d;
   logic [COUNT_W-1:0]    count_q, count_d;
   logic [DATA_WIDTH-1:0] hold_q;
   logic                  valid_q;
   logic                  overrun_q;
   logic [DATA_WIDTH-1:0] word;
   logic                  shift_clr;
   logic                  shift_en;
   logic                  complete;
   logic                  blocked;

   sipo_shift_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_shift_core (
      .Clk_In      (Clk_In),
      .Reset_N_In  (Reset_N_In),
      .Clear_In    (shift_clr),
      .Shift_En_In (shift_en),
      .Data_In     (Serial_Data_In),
      .Word_Out    (word)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      shift_clr = 1'b0;
      shift_en  = 1'b0;
      complete  = 1'b0;
      if (!Enable_In) begin
         state_d   = ST_IDLE;
         count_d   = '0;
         shift_clr = 1'b1;
      end else if (Frame_Start_In) begin
         // A start restarts the word; a bit present this cycle becomes bit 0.
         state_d   = ST_SHIFT;
         shift_clr = 1'b1;
         shift_en  = Serial_Valid_In;
         count_d   = Serial_Valid_In ? COUNT_W'(1) : '0;
      end else if (state_q == ST_SHIFT && Serial_Valid_In) begin
         if (count_q == LAST_BIT) begin
            complete  = 1'b1;
            count_d   = '0;
            shift_clr = 1'b1;
            state_d   = CONTINUOUS ? ST_SHIFT : ST_IDLE;
         end else begin
            shift_en = 1'b1;
            count_d  = count_q + COUNT_W'(1);
         end
      end
   end

   // Holding register is occupied and not being drained this edge.
   assign blocked = valid_q && !Word_Ready_In;

   always_ff @(posedge Clk_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         hold_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         if (complete && !blocked) begin
            hold_q  <= word;
            valid_q <= 1'b1;
         end else if (valid_q && Word_Ready_In) begin
            valid_q <= 1'b0;
         end
         if (complete && blocked) begin
            overrun_q <= 1'b1;
         end else if (Clear_Overrun_In) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign Word_Data_Out  = hold_q;
   assign Word_Valid_Out = valid_q;
   assign Busy_Out       = (state_q == ST_SHIFT);
   assign Bit_Count_Out  = count_q;
   assign Overrun_Out    = overrun_q;

endmodule
